// File: rtl/alu_bfm_pkg.sv
// alu_bfm_pkg: shared types, widths and small datapath helpers for the alu_bfm engine.
package alu_bfm_pkg;

  localparam int OPND_W = 8;
  localparam int RES_W  = 16;

  // Opcode encoding; 5 and 6 are reserved and behave exactly like NOP.
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_MUL  = 3'd4,
    OP_RSV5 = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RST  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

  // Operands and opcode captured at acceptance of a single-cycle op.
  typedef struct packed {
    op_e               op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } issue_t;

  // Ops that travel through the single-cycle issue register (RST included,
  // since it must also act one cycle after acceptance).
  function automatic logic is_issue_op(input op_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_RST);
  endfunction

  // Ops whose completion is signalled with a done pulse on the single-cycle path.
  function automatic logic is_done_op(input op_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
  endfunction

  // Single-cycle result, zero-extended to the result width.
  function automatic logic [RES_W-1:0] single_cycle_result(
    input op_e               op,
    input logic [OPND_W-1:0] a,
    input logic [OPND_W-1:0] b
  );
    logic [RES_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = RES_W'({1'b0, a} + {1'b0, b});
      OP_AND:  r = RES_W'(a & b);
      OP_XOR:  r = RES_W'(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_bfm_mult.sv
// alu_bfm_mult: MULT_LATENCY-stage pipelined 8x8 unsigned multiplier.
// Stage 0 registers the operands, stage 1 registers the product, and any
// further stages only delay it. A valid bit travels alongside the data so the
// async reset flushes any multiply in flight.
module alu_bfm_mult
  import alu_bfm_pkg::*;
#(
  parameter int MULT_LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_vld_i,
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  output logic              out_vld_o,
  output logic [RES_W-1:0]  prod_o
);

  logic [OPND_W-1:0]       opa_q, opa_d;
  logic [OPND_W-1:0]       opb_q, opb_d;
  logic [MULT_LATENCY-1:0] vld_q, vld_d;
  logic [RES_W-1:0]        prod_q [1:MULT_LATENCY-1];
  logic [RES_W-1:0]        prod_d [1:MULT_LATENCY-1];

  // Next-stage values: operands load only on a new request, the rest shifts every cycle.
  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    if (in_vld_i) begin
      opa_d = a_i;
      opb_d = b_i;
    end
    vld_d[0] = in_vld_i;
    for (int k = 1; k < MULT_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
    end
    prod_d[1] = RES_W'(opa_q) * RES_W'(opb_q);
    for (int k = 2; k < MULT_LATENCY; k++) begin
      prod_d[k] = prod_q[k-1];
    end
  end

  // Pipeline registers; reset clears the valid chain so aborted multiplies never complete.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      opa_q <= '0;
      opb_q <= '0;
      vld_q <= '0;
      for (int k = 1; k < MULT_LATENCY; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      opa_q <= opa_d;
      opb_q <= opb_d;
      vld_q <= vld_d;
      for (int k = 1; k < MULT_LATENCY; k++) begin
        prod_q[k] <= prod_d[k];
      end
    end
  end

  assign out_vld_o = vld_q[MULT_LATENCY-1];
  assign prod_o    = prod_q[MULT_LATENCY-1];

endmodule

// File: rtl/alu_bfm.sv
// alu_bfm: 8-bit ALU with start/done handshake. Single-cycle ADD/AND/XOR/RST
// pass through a one-deep issue register; MUL goes through the pipelined
// multiplier while the FSM blocks acceptance for MULT_LATENCY-1 edges.
module alu_bfm
  import alu_bfm_pkg::*;
#(
  parameter int MULT_LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [OPND_W-1:0] A_s,
  input  logic [OPND_W-1:0] B_s,
  input  logic [2:0]        op_s,
  input  logic              start,
  output logic              done,
  output logic [RES_W-1:0]  res_o
);

  // Counter holds the number of busy edges still to come after the current one.
  localparam int CNT_W = (MULT_LATENCY > 2) ? $clog2(MULT_LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  op_e              op_in;
  logic             accept;
  logic             mul_go;

  issue_t           iss_q, iss_d;
  logic             iss_vld_q, iss_vld_d;

  logic [RES_W-1:0] res_q, res_d;
  logic             done_q, done_d;

  logic             mult_vld;
  logic [RES_W-1:0] mult_prod;

  // The enum covers all eight encodings, so the cast is total.
  assign op_in = op_e'(op_s);

  // State register: FSM state and busy counter.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: MUL enters MUL_BUSY, which lasts MULT_LATENCY-1 edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mul_go) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MUL_BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: acceptance only in IDLE; anything presented while busy is dropped.
  always_comb begin
    accept    = (state_q == IDLE) && start;
    mul_go    = accept && (op_in == OP_MUL);
    iss_vld_d = accept && is_issue_op(op_in);
    iss_d     = iss_q;
    if (iss_vld_d) begin
      iss_d = '{op: op_in, a: A_s, b: B_s};
    end
  end

  // Issue register: freezes operands/opcode of an accepted single-cycle op.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      iss_q     <= '{op: OP_NOP, a: '0, b: '0};
      iss_vld_q <= 1'b0;
    end else begin
      iss_q     <= iss_d;
      iss_vld_q <= iss_vld_d;
    end
  end

  alu_bfm_mult #(
    .MULT_LATENCY(MULT_LATENCY)
  ) u_mult (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .in_vld_i (mul_go),
    .a_i      (A_s),
    .b_i      (B_s),
    .out_vld_o(mult_vld),
    .prod_o   (mult_prod)
  );

  // Result mux: multiplier completion and issued ops never land on the same
  // edge, because the FSM blocks acceptance while a multiply is outstanding.
  always_comb begin
    res_d  = res_q;
    done_d = 1'b0;
    if (mult_vld) begin
      res_d  = mult_prod;
      done_d = 1'b1;
    end else if (iss_vld_q) begin
      if (iss_q.op == OP_RST) begin
        res_d = '0;
      end else if (is_done_op(iss_q.op)) begin
        res_d  = single_cycle_result(iss_q.op, iss_q.a, iss_q.b);
        done_d = 1'b1;
      end
    end
  end

  // Result and done registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  assign res_o = res_q;
  assign done  = done_q;

endmodule

// File: tb/tb_alu_bfm.sv
// tb_alu_bfm: directed scenarios plus randomized traffic, checked every cycle
// against a behavioural model that tracks when the block is free and which
// result is due on which clock edge.
module tb_alu_bfm;

  localparam int L = 3;

  logic        clk_i   = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  A_s     = '0;
  logic [7:0]  B_s     = '0;
  logic [2:0]  op_s    = '0;
  logic        start   = 1'b0;
  logic        done;
  logic [15:0] res_o;

  int total = 0;
  int bad   = 0;

  alu_bfm #(.MULT_LATENCY(L)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .A_s    (A_s),
    .B_s    (B_s),
    .op_s   (op_s),
    .start  (start),
    .done   (done),
    .res_o  (res_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: edge counter, first edge at which a request is taken,
  // and at most one scheduled result.
  int          t        = 0;
  int          free_at  = 0;
  bit          pend     = 1'b0;
  int          pend_due = 0;
  logic [15:0] pend_val = '0;
  bit          pend_done = 1'b0;
  logic [15:0] exp_res  = '0;
  bit          exp_done = 1'b0;

  always @(posedge clk_i) begin
    if (!reset_i) begin
      pend     = 1'b0;
      exp_res  = '0;
      exp_done = 1'b0;
      free_at  = t;
    end else begin
      t++;
      exp_done = 1'b0;
      if (pend && pend_due == t) begin
        exp_res  = pend_val;
        exp_done = pend_done;
        pend     = 1'b0;
      end
      if (start && t >= free_at) begin
        case (op_s)
          3'd1: begin pend = 1; pend_due = t + 1; pend_val = 16'(int'(A_s) + int'(B_s)); pend_done = 1; end
          3'd2: begin pend = 1; pend_due = t + 1; pend_val = {8'h00, A_s & B_s}; pend_done = 1; end
          3'd3: begin pend = 1; pend_due = t + 1; pend_val = {8'h00, A_s ^ B_s}; pend_done = 1; end
          3'd4: begin pend = 1; pend_due = t + L; pend_val = 16'(int'(A_s) * int'(B_s)); pend_done = 1; free_at = t + L; end
          3'd7: begin pend = 1; pend_due = t + 1; pend_val = 16'h0000; pend_done = 0; end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of DUT outputs with the model.
  always @(negedge clk_i) begin
    total++;
    if (done !== exp_done) begin
      bad++;
      $display("FAIL cyc_done t=%0d got=%b want=%b", t, done, exp_done);
    end
    total++;
    if (res_o !== exp_res) begin
      bad++;
      $display("FAIL cyc_res t=%0d got=%h want=%h", t, res_o, exp_res);
    end
    if (exp_done) $display("txn t=%0d res=%h done=%b", t, res_o, done);
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic st);
    A_s = a; B_s = b; op_s = op; start = st;
  endtask

  initial begin
    // Reset held with start and random inputs present.
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(8'($urandom), 8'($urandom), 3'($urandom), 1'b1);
      tick();
      chk("reset_res", res_o, 16'h0000);
      chk("reset_done", {15'd0, done}, 16'h0000);
    end
    reset_i = 1'b1;

    // ADD with carry into bit 8.
    set_in(8'hFF, 8'h01, 3'd1, 1'b1);
    tick();
    start = 1'b0;
    tick();
    chk("add_res", res_o, 16'h0100);
    chk("add_done", {15'd0, done}, 16'h0001);
    chk("model_add", exp_res, 16'h0100);
    tick();
    chk("add_done_drop", {15'd0, done}, 16'h0000);

    // AND then XOR back to back.
    set_in(8'hF0, 8'h3C, 3'd2, 1'b1);
    tick();
    set_in(8'hF0, 8'h3C, 3'd3, 1'b1);
    tick();
    chk("and_res", res_o, 16'h0030);
    chk("and_done", {15'd0, done}, 16'h0001);
    start = 1'b0;
    tick();
    chk("xor_res", res_o, 16'h00CC);
    chk("xor_done", {15'd0, done}, 16'h0001);
    tick();
    chk("xor_done_drop", {15'd0, done}, 16'h0000);

    // MUL with start held; ops at N+1, N+2 dropped, op at N+3 accepted.
    set_in(8'hFF, 8'hFF, 3'd4, 1'b1);
    tick();
    set_in(8'h01, 8'h01, 3'd1, 1'b1);
    tick();
    chk("mul_n1_done", {15'd0, done}, 16'h0000);
    set_in(8'h02, 8'h02, 3'd2, 1'b1);
    tick();
    chk("mul_n2_done", {15'd0, done}, 16'h0000);
    chk("mul_n2_res", res_o, 16'h00CC);
    set_in(8'h01, 8'h02, 3'd1, 1'b1);
    tick();
    chk("mul_res", res_o, 16'hFE01);
    chk("mul_done", {15'd0, done}, 16'h0001);
    chk("model_mul", exp_res, 16'hFE01);
    start = 1'b0;
    tick();
    chk("post_mul_res", res_o, 16'h0003);
    chk("post_mul_done", {15'd0, done}, 16'h0001);
    tick();

    // NOP and reserved, then RST.
    set_in(8'h11, 8'h22, 3'd0, 1'b1);
    tick();
    set_in(8'h33, 8'h44, 3'd5, 1'b1);
    tick();
    chk("nop_done", {15'd0, done}, 16'h0000);
    chk("nop_res", res_o, 16'h0003);
    start = 1'b0;
    tick();
    chk("rsv_done", {15'd0, done}, 16'h0000);
    chk("rsv_res", res_o, 16'h0003);
    set_in(8'h55, 8'h66, 3'd7, 1'b1);
    tick();
    start = 1'b0;
    tick();
    chk("rst_res", res_o, 16'h0000);
    chk("rst_done", {15'd0, done}, 16'h0000);

    // Reset one cycle into a multiply aborts it.
    set_in(8'h01, 8'h01, 3'd1, 1'b1);
    tick();
    set_in(8'd10, 8'd20, 3'd4, 1'b1);
    tick();
    start = 1'b0;
    tick();
    #1 reset_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_done", {15'd0, done}, 16'h0000);
      chk("abort_res", res_o, 16'h0000);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset_i = 1'b1;
      set_in(8'($urandom), 8'($urandom), 3'($urandom_range(7)), ($urandom_range(9) != 0));
      if ($urandom_range(299) == 0) begin
        #1 reset_i = 1'b0;
      end
    end
    reset_i = 1'b1;
    start   = 1'b0;
    repeat (L + 2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
